// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, fetch FSM states, PC step.
// Reused by the control decoder.
package cpu_pkg;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   localparam int unsigned PC_INC = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/opcode_legal.sv
// Combinational membership test of an opcode against the supported set.
// Only instantiated when FETCH_ILLEGAL_CHECK_EN is defined.
module opcode_legal
   import cpu_pkg::*;
(
   input  logic [6:0] op,
   output logic       legal
);

   always_comb begin
      legal = 1'b0;
      case (op)
         OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM: legal = 1'b1;
         default:                                         legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch with branch redirect and held output.
// Optional macro FETCH_ILLEGAL_CHECK_EN adds illegal_op and a sticky HALT state.
module instr_fetch
   import cpu_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [6:0]      opcode,
   output logic [XLEN-1:0] pc,
`ifdef FETCH_ILLEGAL_CHECK_EN
   output logic            illegal_op,
`endif
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic            flush_q, flush_d;
   logic [XLEN-1:0] instr_q, pc_q;
   logic            latch;
   logic [XLEN-1:0] br_pc;
   logic            tgt_lsb_unused;

   assign br_pc          = {branch_target[XLEN-1:2], 2'b00};
   assign tgt_lsb_unused = ^branch_target[1:0];

`ifdef FETCH_ILLEGAL_CHECK_EN
   logic op_ok;

   opcode_legal u_legal (
      .op    (instr_q[6:0]),
      .legal (op_ok)
   );

   // Flag immediately in HOLD so an illegal word is never presented as valid.
   assign illegal_op  = (state_q == S_HALT) || ((state_q == S_HOLD) && !op_ok);
   assign instr_valid = (state_q == S_HOLD) && op_ok;
`else
   assign instr_valid = (state_q == S_HOLD);
`endif

   assign imem_req  = (state_q == S_REQ);
   assign imem_addr = fetch_pc_q;
   assign instr     = instr_q;
   assign pc        = pc_q;
   assign opcode    = instr_q[6:0];

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      flush_d    = flush_q;
      latch      = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            state_d = S_WAIT;
            if (branch_taken) begin
               fetch_pc_d = br_pc;
               flush_d    = 1'b1;
            end
         end
         S_WAIT: begin
            if (branch_taken) fetch_pc_d = br_pc;
            if (imem_rvalid) begin
               // A redirect seen now or earlier makes this response stale.
               if (flush_q || branch_taken) begin
                  flush_d = 1'b0;
                  state_d = S_REQ;
               end else begin
                  latch   = 1'b1;
                  state_d = S_HOLD;
               end
            end else if (branch_taken) begin
               flush_d = 1'b1;
            end
         end
         S_HOLD: begin
`ifdef FETCH_ILLEGAL_CHECK_EN
            if (!op_ok) begin
               state_d = S_HALT;
            end else
`endif
            if (branch_taken) begin
               fetch_pc_d = br_pc;
               state_d    = S_REQ;
            end else if (instr_ready) begin
               fetch_pc_d = pc_q + XLEN'(PC_INC);
               state_d    = S_REQ;
            end
         end
`ifdef FETCH_ILLEGAL_CHECK_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         flush_q    <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         flush_q    <= flush_d;
         if (latch) begin
            instr_q <= imem_rdata;
            pc_q    <= fetch_pc_q;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a transaction-level fetch model.
// Define FETCH_ILLEGAL_CHECK_EN to also exercise the illegal-opcode halt.
module tb_instr_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [31:0] pc;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
`ifdef FETCH_ILLEGAL_CHECK_EN
   logic        illegal_op;
`endif

   instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .opcode        (opcode),
      .pc            (pc),
`ifdef FETCH_ILLEGAL_CHECK_EN
      .illegal_op    (illegal_op),
`endif
      .branch_taken  (branch_taken),
      .branch_target (branch_target)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   // Stimulus knobs
   int unsigned p_br = 0, p_rdy = 100, min_lat = 1, max_lat = 1;
   bit          force_br = 0;
   int unsigned force_when = 0;  // 0 any active phase, 1 waiting, 2 holding
   logic [31:0] force_tgt = '0;
   bit          next_illegal = 0;

   // Reference model: expected visible outputs plus the outstanding fetch
   bit          e_req, e_valid, in_idle, outstanding, stale, halted;
   logic [31:0] e_instr, e_pc, exp_addr, req_addr, resp_data;
   int unsigned resp_cnt;
   logic [6:0]  ops [5];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

`ifdef FETCH_ILLEGAL_CHECK_EN
   function automatic bit is_legal(input logic [6:0] o);
      foreach (ops[i]) if (ops[i] == o) return 1'b1;
      return 1'b0;
   endfunction
`endif

   task automatic do_reset();
      reset = 1'b1; branch_taken = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_opcode", 32'(opcode), 32'd0);
      chk("rst_pc", pc, 32'd0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
`ifdef FETCH_ILLEGAL_CHECK_EN
      chk("rst_illegal_op", 32'(illegal_op), 32'd0);
`endif
      reset = 1'b0;
      e_req = 0; e_valid = 0; in_idle = 1; outstanding = 0; stale = 0; halted = 0;
      exp_addr = RESET_PC; force_br = 0;
   endtask

   task automatic step();
      bit          br, rdy, rv, n_req, n_valid, wait_st;
      logic [31:0] tgt, rd, rnd;
      chk("imem_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("imem_addr", imem_addr, exp_addr);
      chk("instr_valid", 32'(instr_valid), 32'(e_valid));
      if (e_valid) begin
         chk("instr", instr, e_instr);
         chk("pc", pc, e_pc);
         chk("opcode", 32'(opcode), 32'(e_instr[6:0]));
      end
`ifdef FETCH_ILLEGAL_CHECK_EN
      chk("illegal_op", 32'(illegal_op), 32'(halted));
`endif
      // stimulus for the coming edge
      wait_st = outstanding && !e_req;
      br = 0; tgt = $urandom();
      if (!in_idle && !halted) begin
         if (force_br && (force_when == 0 || (force_when == 1 && wait_st) ||
                          (force_when == 2 && e_valid))) begin
            br = 1; tgt = force_tgt; force_br = 0;
         end else if (!force_br && $urandom_range(99) < p_br) begin
            br = 1;
            case ($urandom_range(3))
               0: tgt = 32'hFFFF_FFFF;
               1: tgt = 32'h0000_0103;
               default: ;
            endcase
         end
      end
      rdy = ($urandom_range(99) < p_rdy);
      rv = 0; rd = $urandom();
      if (wait_st && resp_cnt == 1) begin
         rv = 1; rd = resp_data;
      end else if (e_valid && $urandom_range(3) == 0) begin
         rv = 1;  // must be ignored outside a pending fetch
      end
      branch_taken = br; branch_target = tgt; instr_ready = rdy;
      imem_rvalid = rv; imem_rdata = rd;
      // model update
      n_req = 0; n_valid = 0;
      if (halted) begin
      end else if (in_idle) begin
         n_req = 1; in_idle = 0;
      end else if (e_req) begin
         outstanding = 1; stale = br; req_addr = exp_addr;
         resp_cnt = $urandom_range(max_lat, min_lat);
         rnd = $urandom();
         resp_data = next_illegal ? 32'h0000_007F : {rnd[31:7], ops[$urandom_range(4)]};
         next_illegal = 0;
         if (br) exp_addr = {tgt[31:2], 2'b00};
      end else if (outstanding) begin
         if (br) exp_addr = {tgt[31:2], 2'b00};
         if (resp_cnt == 1) begin
            outstanding = 0;
            if (stale || br) n_req = 1;
`ifdef FETCH_ILLEGAL_CHECK_EN
            else if (!is_legal(resp_data[6:0])) halted = 1;
`endif
            else begin
               n_valid = 1; e_instr = resp_data; e_pc = req_addr;
            end
            stale = 0;
         end else begin
            resp_cnt--;
            if (br) stale = 1;
         end
      end else if (e_valid) begin
         if (br) begin
            exp_addr = {tgt[31:2], 2'b00}; n_req = 1;
         end else if (rdy) begin
            exp_addr = e_pc + 32'd4; n_req = 1;
         end else begin
            n_valid = 1;
         end
      end
      e_req = n_req; e_valid = n_valid;
      @(negedge clk);
   endtask

   initial begin
      ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011};
      @(negedge clk);
      do_reset();
      repeat (12) step();
      // downstream stall with changing rdata
      p_rdy = 0;   repeat (9) step();
      p_rdy = 100; repeat (4) step();
      // redirect while waiting on a slow response
      min_lat = 3; max_lat = 3;
      force_br = 1; force_when = 1; force_tgt = 32'h0000_0103;
      repeat (14) step();
      // redirect while holding, with ready also high
      min_lat = 1; max_lat = 1;
      force_br = 1; force_when = 2; force_tgt = 32'h0000_0040;
      repeat (10) step();
      // accept at the top of the address space
      force_br = 1; force_when = 0; force_tgt = 32'hFFFF_FFFE;
      repeat (12) step();
      for (int r = 0; r < 6; r++) begin
         p_br = $urandom_range(30); p_rdy = $urandom_range(100, 10);
         max_lat = $urandom_range(4, 1);
         repeat (300) step();
         do_reset();
      end
`ifdef FETCH_ILLEGAL_CHECK_EN
      p_br = 0; p_rdy = 100; min_lat = 1; max_lat = 1;
      repeat (5) step();
      next_illegal = 1;
      repeat (12) step();
      chk("halted_reached", 32'(halted), 32'd1);
      do_reset();
      repeat (8) step();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
